divu_sequencer: RTL and testbench
=================================

# divu_sequencer

Multi-cycle unsigned divider executing the DIVU function (`Signal` = 6'b011011) of the ALU datapath. It is the inverse partner of the sequential multiplier: it runs a 32-step restoring shift-subtract division and delivers a 64-bit result to the HiLo register block. The result layout is remainder in bits [63:32] (HI) and quotient in bits [31:0] (LO), with a one-cycle completion strobe.

## Interface
- `WIDTH`, 32: operand width; quotient and remainder are each `WIDTH` bits.
- `DIVU`, 6'b011011: function code that starts a division.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `dataA`  input  32  dividend; sampled only on the start edge.
- `dataB`  input  32  divisor; sampled only on the start edge.
- `Signal`  input  6  function code; a division starts when it equals `DIVU` in IDLE.
- `dataOut`  output  64  {remainder, quotient}; holds its value between operations.
- `divRes`  output  1  completion strobe; high for exactly one cycle, in DONE.
- `busy`  output  1  high in RUN and DONE.

## Operation
- Registers:
  - `rem` is 33 bits.
  - `quo` is 32 bits.
  - `dvs` is 32 bits.
  - `cnt` is 6 bits.
  - `state` is one of IDLE, RUN, DONE.
  - `dataOut` is a 64-bit register.
- Reset, on any edge with `reset`=1 and regardless of state:
  - state goes to IDLE.
  - `rem`, `quo`, `dvs`, `cnt` and `dataOut` go to 0.
  - `divRes`=0 and `busy`=0.
  - Reset has priority over start.
- IDLE, when `Signal`==DIVU:
  - load `quo`←dataA, `dvs`←dataB, `rem`←0, `cnt`←0.
  - go to RUN.
  - Any other code: remain in IDLE.
- RUN, one step per edge:
  - compute t = {rem[31:0], quo[31]} − {1'b0, dvs}, in 33 bits.
  - if t[32]==0: rem←t and quo←{quo[30:0],1}.
  - otherwise: rem←{rem[31:0],quo[31]} and quo←{quo[30:0],0}.
  - `cnt`←cnt+1.
  - On the step where cnt==31, also load `dataOut`←{next rem[31:0], next quo} and go to DONE.
- DONE:
  - `divRes`=1 for this cycle only.
  - next edge: go to IDLE.
  - `Signal` is ignored in DONE. A new DIVU must be presented in IDLE.
- `Signal`, `dataA` and `dataB` changes during RUN/DONE are ignored. Operands are fully latched.
- Divide by zero (dataB==0) takes no special path. Every trial subtraction succeeds, so the quotient is 0xFFFFFFFF and the remainder is dataA. Latency is unchanged.
- `dataOut` changes only on the completion edge or on reset. HiLo captures it on the `divRes` cycle.
- `divRes` and `busy` are decoded from the state register with no combinational path from inputs.

## Timing
- E0 is the edge where IDLE samples `Signal`==DIVU.
  - Edges E1..E32 perform the 32 division steps.
  - State becomes DONE and `dataOut` is valid after E32.
  - `divRes`=1 between E32 and E33.
  - State is IDLE after E33. The earliest next start edge is E34, since E33 sampling occurs in DONE.
- Total occupancy: 34 cycles per division when issued back-to-back.
- `busy` rises after E0 and falls after E33.
- Reset asserted at any edge during RUN aborts the operation:
  - no `divRes` pulse.
  - `dataOut`=0 after that edge.
  - a DIVU presented with `reset`=0 on the following edge starts normally.

## Test plan
- dataA=100, dataB=7, `Signal`=DIVU for one cycle:
  - `divRes` pulses once, 32 edges after the start edge.
  - `dataOut`=0x00000002_0000000E.
  - `busy` is high for 33 cycles.
- dataA=0xFFFFFFFF, dataB=1, then dataA=5, dataB=9, back-to-back with `Signal` held at DIVU throughout:
  - first result 0x00000000_FFFFFFFF.
  - second start accepted only at E34.
  - second result 0x00000005_00000000.
  - no extra `divRes` pulses.
- dataA=0x12345678, dataB=0:
  - `dataOut`=0x12345678_FFFFFFFF.
  - standard 32-edge latency.
- Start 1000/10, then change dataA, dataB and `Signal` (to 6'b100000) every cycle during RUN:
  - result 0x00000000_00000064, unaffected by the changes.
- Start 1000/10, then assert `reset` on E10:
  - `busy`=0 and `dataOut`=0 after E10.
  - no `divRes` pulse.
  - a new 0x80000000/0x00010000 started after reset gives 0x00000000_00008000.
- With `Signal` at DIVU, hold `reset`=1:
  - no start occurs.
  - all outputs stay 0.

Source files
------------

// File: rtl/divu_sequencer.sv
// Sequential unsigned divider: 32-step restoring shift-subtract, result {remainder, quotient}.
// Completion is a one-cycle strobe for the HiLo block; operands are latched at start.
module divu_sequencer #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  DIVU  = 6'b011011
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 divRes,
    output logic                 busy,
    output logic [1:0]           dbgState
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [5:0]       cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   remNext;
    logic [WIDTH-1:0] quoNext;
    logic             unusedRemTop;

    // The partial remainder never exceeds the divisor, so its top bit only
    // exists to catch the trial borrow and is never shifted back in.
    assign unusedRemTop = rem[WIDTH];

    always_comb begin
        shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        remNext = shifted;
        quoNext = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            remNext = trial;
            quoNext = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            dataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Signal == DIVU) begin
                        quo   <= dataA;
                        dvs   <= dataB;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rem <= remNext;
                    quo <= quoNext;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        dataOut <= {remNext[WIDTH-1:0], quoNext};
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake: a start is accepted only in IDLE; divRes is high for exactly
    // one cycle with dataOut already valid; busy covers RUN and DONE.
    assign divRes   = (state == DONE);
    assign busy     = (state != IDLE);
    assign dbgState = state;

endmodule

// File: tb/tb_divu_sequencer.sv
// Self-checking bench for divu_sequencer: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_divu_sequencer;

    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] OTHER = 6'b000000;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [63:0] dataOut;
    logic        divRes;
    logic        busy;
    logic [1:0]  dbgState;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [63:0] exp_q[$];

    divu_sequencer #(.WIDTH(32), .DIVU(DIVU)) dut (
        .clk      (clk),
        .reset    (reset),
        .dataA    (dataA),
        .dataB    (dataB),
        .Signal   (Signal),
        .dataOut  (dataOut),
        .divRes   (divRes),
        .busy     (busy),
        .dbgState (dbgState)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (divRes === 1'b1) pulses++;

    // reference: quotient and remainder from plain arithmetic
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    // driver: present DIVU for one edge (E0); returns 1 time unit after E0
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        dataA  = a;
        dataB  = b;
        Signal = DIVU;
        @(posedge clk); #1;
        Signal = OTHER;
    endtask

    // monitor: from just after E0, follow the operation until it returns to idle
    task automatic wait_done(input bit scramble, output int lat, output int busyCyc,
                             output logic [63:0] res);
        lat = -1; busyCyc = 0; res = '0;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) begin
                if (scramble) begin
                    dataA  = $urandom;
                    dataB  = $urandom;
                    Signal = 6'b100000;
                end
                @(posedge clk); #1;
            end
            if (busy === 1'b1) busyCyc++;
            if (divRes === 1'b1 && lat < 0) begin
                lat = k;
                res = dataOut;
            end
            if (lat >= 0 && busy === 1'b0) break;
        end
        Signal = OTHER;
    endtask

    task automatic test_reset();
        reset = 1'b1; Signal = DIVU; dataA = 32'd100; dataB = 32'd7;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (dataOut !== 64'd0 || divRes !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: dataOut=%h divRes=%b busy=%b, expected 0/0/0",
                         i, dataOut, divRes, busy);
            end
        end
        checks++;
        if (dbgState !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", dbgState);
        end
        Signal = OTHER;
        reset  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, busyCyc, p0;
        logic [63:0] res;
        p0 = pulses;
        start_div(32'd100, 32'd7);
        wait_done(1'b0, lat, busyCyc, res);
        checks++;
        if (lat !== 32) begin
            errors++; $display("FAIL basic_latency: got %0d expected 32", lat);
        end
        checks++;
        if (res !== 64'h00000002_0000000E) begin
            errors++; $display("FAIL basic_result: got %h expected 000000020000000e", res);
        end
        checks++;
        if (busyCyc !== 33) begin
            errors++; $display("FAIL basic_busy: got %0d cycles expected 33", busyCyc);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dataOut !== 64'h00000002_0000000E) begin
            errors++; $display("FAIL basic_hold: got %h expected 000000020000000e", dataOut);
        end
        checks++;
        if (pulses - p0 !== 1) begin
            errors++; $display("FAIL basic_pulses: got %0d expected 1", pulses - p0);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, restart, idleGaps, p0;
        logic [63:0] r1, r2;
        first = -1; second = -1; restart = -1; idleGaps = 0; r1 = '0; r2 = '0;
        p0 = pulses;
        dataA = 32'hFFFF_FFFF; dataB = 32'd1; Signal = DIVU;
        @(posedge clk); #1;
        dataA = 32'd5; dataB = 32'd9;
        for (int k = 1; k <= 75; k++) begin
            @(posedge clk); #1;
            if (busy === 1'b0 && first >= 0 && restart < 0) idleGaps++;
            if (busy === 1'b1 && first >= 0 && restart < 0 && idleGaps > 0) restart = k;
            if (divRes === 1'b1) begin
                if (first < 0) begin first = k; r1 = dataOut; end
                else if (second < 0) begin second = k; r2 = dataOut; Signal = OTHER; end
            end
        end
        Signal = OTHER;
        checks++;
        if (first !== 32 || r1 !== 64'h00000000_FFFFFFFF) begin
            errors++; $display("FAIL b2b_first: edge %0d result %h, expected edge 32 result 00000000ffffffff", first, r1);
        end
        checks++;
        if (restart !== 34 || idleGaps !== 1) begin
            errors++; $display("FAIL b2b_restart: edge %0d gaps %0d, expected edge 34 gaps 1", restart, idleGaps);
        end
        checks++;
        if (second !== 66 || r2 !== 64'h00000005_00000000) begin
            errors++; $display("FAIL b2b_second: edge %0d result %h, expected edge 66 result 0000000500000000", second, r2);
        end
        checks++;
        if (pulses - p0 !== 2) begin
            errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses - p0);
        end
    endtask

    task automatic test_div_zero();
        int lat, busyCyc;
        logic [63:0] res;
        start_div(32'h1234_5678, 32'd0);
        wait_done(1'b0, lat, busyCyc, res);
        checks++;
        if (lat !== 32 || res !== 64'h12345678_FFFFFFFF) begin
            errors++; $display("FAIL div_zero: latency %0d result %h, expected 32 and 12345678ffffffff", lat, res);
        end
    endtask

    task automatic test_input_changes();
        int lat, busyCyc;
        logic [63:0] res;
        start_div(32'd1000, 32'd10);
        wait_done(1'b1, lat, busyCyc, res);
        checks++;
        if (lat !== 32 || res !== 64'h00000000_00000064) begin
            errors++; $display("FAIL latch_operands: latency %0d result %h, expected 32 and 0000000000000064", lat, res);
        end
    endtask

    task automatic test_abort();
        int lat, busyCyc, p0;
        logic [63:0] res;
        p0 = pulses;
        start_div(32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || dataOut !== 64'd0 || divRes !== 1'b0) begin
            errors++; $display("FAIL abort_state: busy=%b dataOut=%h divRes=%b, expected 0/0/0", busy, dataOut, divRes);
        end
        checks++;
        if (pulses - p0 !== 0) begin
            errors++; $display("FAIL abort_pulses: got %0d expected 0", pulses - p0);
        end
        reset = 1'b0;
        start_div(32'h8000_0000, 32'h0001_0000);
        wait_done(1'b0, lat, busyCyc, res);
        checks++;
        if (lat !== 32 || res !== 64'h00000000_00008000) begin
            errors++; $display("FAIL abort_restart: latency %0d result %h, expected 32 and 0000000000008000", lat, res);
        end
    endtask

    task automatic test_random();
        int lat, busyCyc;
        logic [63:0] res, exp;
        logic [31:0] a, b;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 15);
                1:       b = a + 32'($urandom_range(0, 2)) - 32'd1;
                default: b = $urandom;
            endcase
            exp_q.push_back(ref_div(a, b));
            start_div(a, b);
            wait_done(1'b0, lat, busyCyc, res);
            exp = exp_q.pop_front();
            checks++;
            if (lat !== 32 || res !== exp) begin
                errors++;
                $display("FAIL random_%0d (%h/%h): latency %0d result %h, expected 32 and %h",
                         n, a, b, lat, res, exp);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; Signal = OTHER; dataA = '0; dataB = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        test_div_zero();
        test_input_changes();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
